bin_to_bcd_seq: RTL

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin_to_bcd_seq.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter, one bit/clock.
//            Optional macro BCD_SAT_EN: saturate O_BCD to all 9s on overflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_bcd_seq #(
    parameter int BIN_LEN    = 10,
    parameter int BCD_DIGITS = 3,
    parameter int BCD_LEN    = 4 * BCD_DIGITS
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               I_ST,
    input  logic [BIN_LEN-1:0] I_BIN,
    output logic [BCD_LEN-1:0] O_BCD,
    output logic               O_BUSY,
    output logic               O_DONE,
    output logic               O_OVF
);

    localparam int NIB   = BCD_DIGITS + 1;
    localparam int SR_W  = 4 * NIB + BIN_LEN;
    localparam int CNT_W = $clog2(BIN_LEN + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic               w_last;

    logic [SR_W-1:0]    r_sr;
    logic [SR_W-1:0]    w_corr;
    logic [SR_W-1:0]    w_shift;
    logic [CNT_W-1:0]   r_cnt;

    logic [BCD_LEN-1:0] r_bcd;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic [BCD_LEN-1:0] w_bcd_res;
    logic               w_ovf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_ST) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Binary bits pass through untouched; every BCD nibble gets its add-3 fix-up
    assign w_corr[BIN_LEN-1:0] = r_sr[BIN_LEN-1:0];

    for (genvar g = 0; g < NIB; g++) begin : g_nib
        localparam int LO = BIN_LEN + 4 * g;
        assign w_corr[LO+3:LO] = (r_sr[LO+3:LO] >= 4'd5) ? (r_sr[LO+3:LO] + 4'd3)
                                                         : r_sr[LO+3:LO];
    end

    assign w_shift = {w_corr[SR_W-2:0], 1'b0};
    assign w_ovf   = (w_shift[SR_W-1 -: 4] != 4'd0);

`ifdef BCD_SAT_EN
    assign w_bcd_res = w_ovf ? {BCD_DIGITS{4'h9}} : w_shift[BIN_LEN +: BCD_LEN];
`else
    assign w_bcd_res = w_shift[BIN_LEN +: BCD_LEN];
`endif

    // Results are only written on the final shift so they hold while busy
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sr   <= '0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_sr   <= {{(4 * NIB){1'b0}}, I_BIN};
                r_cnt  <= CNT_W'(BIN_LEN);
                r_busy <= 1'b1;
            end else if (r_state == S_CONV) begin
                r_sr  <= w_shift;
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                    r_bcd  <= w_bcd_res;
                    r_ovf  <= w_ovf;
                end
            end
        end
    end

    assign O_BCD  = r_bcd;
    assign O_BUSY = r_busy;
    assign O_DONE = r_done;
    assign O_OVF  = r_ovf;

endmodule

`default_nettype wire
